// File: rtl/decode_stage_pkg.sv
// Shared decode types: decoded-instruction record, operation classes and the
// serialisation predicate used when forming issue groups.
package decode_stage_pkg;

    localparam int XLEN         = 32;
    localparam int FETCH_WIDTH  = 2;
    localparam int DECODE_WIDTH = 2;
    localparam int IQ_DEPTH     = 8;

    typedef enum logic [4:0] {
        ILLEGAL, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU,
        FENCE, FENCE_I, SFENCE_VMA, ECALL, EBREAK, MRET, SRET, WFI,
        CSR_READ, CSR_RW
    } op_t;

    typedef struct packed {
        logic            valid;
        op_t             op;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
    } si_t;

    typedef struct packed {
        logic [DECODE_WIDTH-1:0] valid;
        si_t [DECODE_WIDTH-1:0]  si;
    } decode_group_t;

    function automatic logic is_serializing(input si_t si);
        return si.op inside {FENCE, FENCE_I, SFENCE_VMA, ECALL, EBREAK,
                             MRET, SRET, WFI, CSR_READ, CSR_RW};
    endfunction

endpackage

// File: rtl/decode_queue.sv
// In-order circular buffer: up to WR_WIDTH contiguous writes and RD_WIDTH
// combinational head reads per cycle, with an occupancy count.
module decode_queue #(
    parameter  int DEPTH    = 8,
    parameter  int WR_WIDTH = 2,
    parameter  int RD_WIDTH = 2,
    parameter  int ENTRY_W  = 64,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             wr_en,
    input  logic [WR_WIDTH-1:0]              wr_mask,
    input  logic [WR_WIDTH-1:0][ENTRY_W-1:0] wr_data,
    input  logic [CNT_W-1:0]                 rd_num,
    output logic [RD_WIDTH-1:0][ENTRY_W-1:0] rd_data,
    output logic [CNT_W-1:0]                 count
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   enq_num;

    always_comb begin
        enq_num = '0;
        for (int i = 0; i < WR_WIDTH; i++) begin
            if (wr_en && wr_mask[i]) enq_num = enq_num + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(rd_num);
            tail_reg  <= tail_reg + PTR_W'(enq_num);
            count_reg <= count_reg + enq_num - rd_num;
        end
    end

    // The mask is contiguous, so slot i always lands at tail + i.
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) begin
            for (int i = 0; i < WR_WIDTH; i++) begin
                if (wr_mask[i]) mem[tail_reg + PTR_W'(i)] <= wr_data[i];
            end
        end
    end

    for (genvar gi = 0; gi < RD_WIDTH; gi++) begin : g_rd
        assign rd_data[gi] = mem[head_reg + PTR_W'(gi)];
    end

    assign count = count_reg;

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_reg <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        rd_num <= count_reg);

endmodule

// File: rtl/static_decoder.sv
// Purely combinational RV32I/Zicsr/privileged decoder for one instruction word.
module static_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output si_t             si
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];

    always_comb begin
        si        = '0;
        si.pc     = pc;
        si.rd     = rd;
        si.rs1    = rs1;
        si.rs2    = inst[24:20];
        si.funct3 = f3;
        si.op     = ILLEGAL;
        si.imm    = {{20{inst[31]}}, inst[31:20]};
        case (opcode)
            7'b0110111: begin si.op = LUI;   si.imm = {inst[31:12], 12'b0}; end
            7'b0010111: begin si.op = AUIPC; si.imm = {inst[31:12], 12'b0}; end
            7'b1101111: begin
                si.op  = JAL;
                si.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: if (f3 == 3'b000) si.op = JALR;
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
                si.op  = BRANCH;
                si.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) si.op = LOAD;
            7'b0100011: if (f3 <= 3'b010) begin
                si.op  = STORE;
                si.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b0010011: si.op = ALU_IMM;
            7'b0110011: if (f7 == 7'b0000000 || f7 == 7'b0100000) si.op = ALU;
            7'b0001111: begin
                if (f3 == 3'b000)      si.op = FENCE;
                else if (f3 == 3'b001) si.op = FENCE_I;
            end
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    if (inst == 32'h0000_0073)                  si.op = ECALL;
                    else if (inst == 32'h0010_0073)             si.op = EBREAK;
                    else if (inst == 32'h3020_0073)             si.op = MRET;
                    else if (inst == 32'h1020_0073)             si.op = SRET;
                    else if (inst == 32'h1050_0073)             si.op = WFI;
                    else if (f7 == 7'b0001001 && rd == 5'd0)    si.op = SFENCE_VMA;
                end else if (f3 != 3'b100) begin
                    // set/clear forms with a zero source never modify the CSR
                    si.op  = (f3[1] && rs1 == 5'd0) ? CSR_READ : CSR_RW;
                    si.imm = {20'b0, inst[31:20]};
                end
            end
            default: ;
        endcase
        si.valid = (si.op != ILLEGAL);
    end

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage: queues fetch packets, decodes the head entries and
// registers an in-order issue group for rename, serialising system instructions.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int FETCH_WIDTH  = decode_stage_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = decode_stage_pkg::DECODE_WIDTH,
    parameter int DEPTH        = decode_stage_pkg::IQ_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              fetch_valid_i,
    output logic                              fetch_ready_o,
    input  logic [FETCH_WIDTH-1:0]            fetch_mask_i,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0]  fetch_pc_i,
    input  logic [FETCH_WIDTH-1:0][31:0]      fetch_data_i,
    output logic [DECODE_WIDTH-1:0]           dec_valid_o,
    output si_t [DECODE_WIDTH-1:0]            dec_si_o,
    input  logic                              dec_ready_i,
    output logic                              empty_o
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = XLEN + 32;

    logic [CNT_W-1:0]                      count;
    logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]   wr_entry;
    logic [DECODE_WIDTH-1:0][ENTRY_W-1:0]  head_entry;
    si_t [DECODE_WIDTH-1:0]                lane_si;
    logic [DECODE_WIDTH-1:0]               grp_valid;
    logic [CNT_W-1:0]                      grp_size;
    logic [CNT_W-1:0]                      pop_num;
    logic                                  grp_stop;
    logic                                  out_load;

    // Based on registered count only, so dec_ready_i never reaches fetch_ready_o.
    assign fetch_ready_o = ({1'b0, count} + (CNT_W + 1)'(FETCH_WIDTH)) <= (CNT_W + 1)'(DEPTH);

    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
        assign wr_entry[gi] = {fetch_pc_i[gi], fetch_data_i[gi]};
    end

    decode_queue #(
        .DEPTH    (DEPTH),
        .WR_WIDTH (FETCH_WIDTH),
        .RD_WIDTH (DECODE_WIDTH),
        .ENTRY_W  (ENTRY_W)
    ) u_queue (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .wr_en    (fetch_valid_i && fetch_ready_o),
        .wr_mask  (fetch_mask_i),
        .wr_data  (wr_entry),
        .rd_num   (pop_num),
        .rd_data  (head_entry),
        .count    (count)
    );

    for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_lane
        static_decoder u_dec (
            .inst (head_entry[gi][31:0]),
            .pc   (head_entry[gi][ENTRY_W-1:32]),
            .si   (lane_si[gi])
        );
    end

    always_comb begin
        grp_valid = '0;
        grp_size  = '0;
        grp_stop  = 1'b0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (!grp_stop && i < int'(count)) begin
                if (i > 0 && is_serializing(lane_si[i])) begin
                    grp_stop = 1'b1;
                end else begin
                    grp_valid[i] = 1'b1;
                    grp_size     = grp_size + CNT_W'(1);
                    if (!lane_si[i].valid || is_serializing(lane_si[i])) grp_stop = 1'b1;
                end
            end else begin
                grp_stop = 1'b1;
            end
        end
    end

    assign out_load = !(|dec_valid_o) || dec_ready_i;
    assign pop_num  = out_load ? grp_size : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_valid_o <= '0;
            dec_si_o    <= '0;
        end else if (flush_i) begin
            dec_valid_o <= '0;
            dec_si_o    <= '0;
        end else if (out_load) begin
            dec_valid_o <= grp_valid;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                dec_si_o[i] <= grp_valid[i] ? lane_si[i] : '0;
            end
        end
    end

    assign empty_o = (count == '0) && !(|dec_valid_o);

    a_mask_contig: assert property (@(posedge clk_i) disable iff (rst_i)
        fetch_valid_i |-> ((fetch_mask_i & FETCH_WIDTH'(fetch_mask_i + 1'b1)) == '0));
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (|dec_valid_o && !dec_ready_i && !flush_i) |=> $stable(dec_si_o));

endmodule
